// File: rtl/rv64_pipe_pkg.sv
// Shared pipeline types for the RV64 stage buffers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv64_pipe_pkg;

  // Canonical bubble instruction: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // One fetched instruction together with its PC and fall-through PC
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [31:0] instr;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_fifo_if.sv
// Fetch-to-decode handshake bundle: upstream push side, downstream pop side, flush.
// Latency: n/a (wiring only).
// Backpressure: o_ready towards fetch, i_ready from decode.
interface if_id_fifo_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int CNT_W       = 3
);
  logic                   flush;
  logic                   i_valid;
  logic                   o_ready;
  logic [DATA_WIDTH-1:0]  i_pc;
  logic [DATA_WIDTH-1:0]  i_pc4;
  logic [INSTR_WIDTH-1:0] i_instr;
  logic                   o_valid;
  logic                   i_ready;
  logic [DATA_WIDTH-1:0]  o_pc;
  logic [DATA_WIDTH-1:0]  o_pc4;
  logic [INSTR_WIDTH-1:0] o_instr;
  logic [CNT_W-1:0]       o_count;

  // Fetch/decode side: drives pushes, consumes the head
  modport master (
    output flush, i_valid, i_pc, i_pc4, i_instr, i_ready,
    input  o_ready, o_valid, o_pc, o_pc4, o_instr, o_count
  );

  // Buffer side
  modport slave (
    input  flush, i_valid, i_pc, i_pc4, i_instr, i_ready,
    output o_ready, o_valid, o_pc, o_pc4, o_instr, o_count
  );
endinterface

// File: rtl/if_id_fifo_mem.sv
// DEPTH x W register array, one synchronous write port, one asynchronous read port.
// Latency: write visible on rdata the cycle after the write edge; read is combinational.
// Backpressure: none; the caller gates we.
module fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 160,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  // Storage is cleared on reset so no stale entry ever leaks out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_fifo.sv
// IF/ID decoupling buffer holding up to DEPTH {pc, pc4, instr} entries.
// Latency: 1 cycle from push edge to head visible on o_*.
// Backpressure: o_ready drops when full (count only, a same-cycle pop does not free a slot).
module if_id_fifo
  import rv64_pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic clk,
  input  logic rst,
  if_id_fifo_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int EW    = 2 * DATA_WIDTH + INSTR_WIDTH;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             mem_we;
  logic [EW-1:0]    wdata;
  logic [EW-1:0]    rdata;

  assign bus.o_ready = (count != CNT_W'(DEPTH));
  assign bus.o_valid = (count != '0);
  assign push        = bus.i_valid & bus.o_ready;
  assign pop         = bus.o_valid & bus.i_ready;
  // A push in a flush cycle is dropped, so storage must not be written either
  assign mem_we      = push & ~bus.flush;
  assign wdata       = {bus.i_pc, bus.i_pc4, bus.i_instr};

  fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Pointer and occupancy update: reset beats flush beats push/pop
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Empty buffer presents a bubble rather than whatever sits at rd_ptr
  always_comb begin
    bus.o_pc    = '0;
    bus.o_pc4   = '0;
    bus.o_instr = INSTR_WIDTH'(NOP_INSTR);
    if (bus.o_valid) begin
      bus.o_pc    = rdata[EW-1 -: DATA_WIDTH];
      bus.o_pc4   = rdata[INSTR_WIDTH +: DATA_WIDTH];
      bus.o_instr = rdata[INSTR_WIDTH-1:0];
    end
  end

  assign bus.o_count = count;
endmodule

// File: doc/if_id_fifo.md
# if_id_fifo

Parametrised IF/ID decoupling buffer, the successor to the single-entry IF/ID register. It holds up to DEPTH fetched instructions with their PC and PC+4, and uses valid/ready handshakes on both sides instead of a global enable. Flush discards all entries in one cycle. It sits between the fetch unit and the decoder, so fetch can keep running while decode is stalled.

## Interface
- DATA_WIDTH, 64, width of PC and PC+4 fields
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, entry count; power of two, minimum 2
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  discard all entries (branch or trap redirect)
- i_valid  in  1  upstream entry present
- o_ready  out  1  buffer accepts an entry this cycle
- i_pc  in  DATA_WIDTH  fetched PC
- i_pc4  in  DATA_WIDTH  fetched PC+4
- i_instr  in  INSTR_WIDTH  fetched instruction
- o_valid  out  1  head entry present
- i_ready  in  1  decoder consumes the head this cycle
- o_pc  out  DATA_WIDTH  head PC
- o_pc4  out  DATA_WIDTH  head PC+4
- o_instr  out  INSTR_WIDTH  head instruction
- o_count  out  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: circular array of DEPTH entries {pc, pc4, instr}; write pointer wr_ptr, read pointer rd_ptr (log2 DEPTH bits each, natural wrap), plus count register.
- push = i_valid & o_ready; pop = o_valid & i_ready.
- o_ready = (count != DEPTH). This is based on count only: no push is accepted while full, even when a pop happens in the same cycle.
- o_valid = (count != 0).
- Push: write the entry at wr_ptr, then wr_ptr+1. Pop: rd_ptr+1. Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop with count 1..DEPTH-1: both proceed, count unchanged. At count 0, pop is impossible (o_valid=0). At count DEPTH, push is impossible.
- Output when o_valid=0: o_pc=0, o_pc4=0, o_instr=NOP (0x00000013), so the decoder sees a bubble.
- Output when o_valid=1: head entry at rd_ptr, read combinationally from registered storage.
- Flush: pointers and count go to 0. A push or pop presented in the flush cycle is discarded. Storage contents are don't-care.
- Priority: rst > flush > push/pop.

## Timing
- Reset values: o_valid=0, o_count=0, o_ready=1 (from the first cycle after rst deasserts), o_pc=0, o_pc4=0, o_instr=NOP. Pointers are 0; storage is cleared to 0.
- Reset mid-operation: all entries are lost and the outputs above appear the cycle after rst is sampled high. Handshakes during rst cycles are ignored.
- Latency: an entry pushed at edge N is visible on o_* with o_valid=1 after edge N. Minimum IF-to-ID latency is 1 cycle, the same as the single-entry register.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Flush asserted at edge N: o_valid=0 and o_ready=1 after edge N.
- Upstream must hold i_* stable while i_valid=1 and o_ready=0. Downstream may deassert i_ready at any time.

## Structure
- Shared package rv64_pipe_pkg: NOP_INSTR constant (32'h00000013) and a packed if_id_entry_t {pc, pc4, instr} typedef, both reused by later stage buffers.
- One natural sub-module: fifo_mem, a DEPTH x entry register array with one write port and one asynchronous read port, reset-cleared.
- The pointer, count and handshake logic stays in if_id_fifo.

## Test plan
- **Reset:** hold rst for 2 cycles with i_valid=1 -> o_valid=0, o_count=0, o_instr=0x00000013; o_ready=1 after release; nothing stored.
- **Fill to full:** i_ready=0, push pc 0x1000/0x1004/0x1008/0x100C (DEPTH=4) -> o_count=4, o_ready=0, a fifth entry is rejected, o_pc=0x1000.
- **Drain in order:** from full, i_ready=1, i_valid=0 -> o_pc is 0x1000, 0x1004, 0x1008, 0x100C on successive cycles, then o_valid=0 and o_instr=NOP.
- **Streaming and wrap:** i_valid=1 and i_ready=1 for 10 cycles with incrementing PCs -> o_count stays 1 after the first cycle, each PC is delivered exactly once in order, and the pointers wrap past DEPTH.
- **Flush with a pending push:** count=3, assert flush together with i_valid=1 pc=0x2000 -> next cycle count=0 and o_valid=0; 0x2000 is never output.
- **Full with simultaneous pop:** count=4, i_valid=1 and i_ready=1 -> head is popped, push is rejected (o_ready=0), count becomes 3.
